// File: rtl/rob_superscalar.sv
// rob_superscalar: N-wide reorder buffer with in-order multi-lane retire
// and single-cycle flush on a retiring mispredicted branch or external squash.
module rob_superscalar #(
    parameter  int DEPTH  = 32,
    parameter  int DISP_W = 2,
    parameter  int CDB_W  = 2,
    parameter  int RET_W  = 2,
    parameter  int XLEN   = 32,
    parameter  int REG_W  = 5,
    localparam int T      = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [DISP_W-1:0]       dp_valid,
    input  logic [DISP_W*REG_W-1:0] dp_dest,
    input  logic [DISP_W*XLEN-1:0]  dp_pc,
    input  logic [DISP_W*XLEN-1:0]  dp_npc,
    input  logic [DISP_W-1:0]       dp_is_branch,
    output logic                    dp_ready,
    output logic [DISP_W*T-1:0]     dp_tag,
    input  logic [CDB_W-1:0]        cdb_valid,
    input  logic [CDB_W*T-1:0]      cdb_tag,
    input  logic [CDB_W*XLEN-1:0]   cdb_value,
    input  logic [CDB_W-1:0]        cdb_taken,
    input  logic [CDB_W*XLEN-1:0]   cdb_target,
    output logic [RET_W-1:0]        rt_valid,
    output logic [RET_W*REG_W-1:0]  rt_dest,
    output logic [RET_W*XLEN-1:0]   rt_value,
    output logic [RET_W*T-1:0]      rt_tag,
    output logic                    mispredict,
    output logic [XLEN-1:0]         redirect_pc,
    output logic [T:0]              free_count
);
    localparam logic [T:0] DEPTH_N = (T+1)'(DEPTH);
    localparam logic [T:0] DISP_N  = (T+1)'(DISP_W);
    localparam logic [T:0] ONE     = (T+1)'(1);

    logic [DEPTH-1:0] e_valid, e_done, e_br, e_taken;
    logic [REG_W-1:0] e_dest   [DEPTH];
    logic [XLEN-1:0]  e_pc     [DEPTH];
    logic [XLEN-1:0]  e_npc    [DEPTH];
    logic [XLEN-1:0]  e_value  [DEPTH];
    logic [XLEN-1:0]  e_target [DEPTH];

    logic [T:0] head, tail, free_q;
    logic [T:0] n_ret, n_disp;
    logic       accept;

    assign free_count = free_q;
    assign dp_ready   = free_q >= DISP_N;
    assign accept     = dp_ready & ~mispredict & ~squash;

    always_comb begin
        n_disp = '0;
        dp_tag = '0;
        for (int i = 0; i < DISP_W; i++) begin
            dp_tag[i*T +: T] = tail[T-1:0] + T'(i);
            if (accept && dp_valid[i])
                n_disp = n_disp + ONE;
        end
    end

    // Retire group: contiguous completed entries from head, cut after a branch.
    always_comb begin
        logic            run;
        logic [T-1:0]    ridx;
        logic [XLEN-1:0] actual;
        run         = 1'b1;
        ridx        = '0;
        actual      = '0;
        n_ret       = '0;
        rt_valid    = '0;
        rt_dest     = '0;
        rt_value    = '0;
        rt_tag      = '0;
        mispredict  = 1'b0;
        redirect_pc = '0;
        for (int k = 0; k < RET_W; k++) begin
            ridx = head[T-1:0] + T'(k);
            if (run && e_valid[ridx] && e_done[ridx]) begin
                rt_valid[k]              = 1'b1;
                rt_dest[k*REG_W +: REG_W] = e_dest[ridx];
                rt_value[k*XLEN +: XLEN] = e_value[ridx];
                rt_tag[k*T +: T]         = ridx;
                n_ret                    = n_ret + ONE;
                if (e_br[ridx]) begin
                    actual = e_taken[ridx] ? e_target[ridx]
                                           : e_pc[ridx] + XLEN'(4);
                    if (actual != e_npc[ridx]) begin
                        mispredict  = 1'b1;
                        redirect_pc = actual;
                    end
                    run = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head    <= '0;
            tail    <= '0;
            free_q  <= DEPTH_N;
            e_valid <= '0;
            e_done  <= '0;
        end else if (mispredict) begin
            head    <= head + n_ret;
            tail    <= head + n_ret;
            free_q  <= DEPTH_N;
            e_valid <= '0;
        end else begin
            head   <= head + n_ret;
            tail   <= tail + n_disp;
            free_q <= free_q + n_ret - n_disp;
            for (int k = 0; k < RET_W; k++)
                if (rt_valid[k])
                    e_valid[head[T-1:0] + T'(k)] <= 1'b0;
            for (int c = 0; c < CDB_W; c++)
                if (cdb_valid[c] && e_valid[cdb_tag[c*T +: T]])
                    e_done[cdb_tag[c*T +: T]] <= 1'b1;
            for (int i = 0; i < DISP_W; i++)
                if (accept && dp_valid[i]) begin
                    e_valid[tail[T-1:0] + T'(i)] <= 1'b1;
                    e_done[tail[T-1:0] + T'(i)]  <= 1'b0;
                end
        end
    end

    // Payload needs no reset: the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (!reset && dp_ready)
            assert ((dp_valid & (dp_valid + DISP_W'(1))) == '0);
        for (int c = 0; c < CDB_W; c++)
            if (cdb_valid[c] && e_valid[cdb_tag[c*T +: T]]) begin
                e_value[cdb_tag[c*T +: T]]  <= cdb_value[c*XLEN +: XLEN];
                e_taken[cdb_tag[c*T +: T]]  <= cdb_taken[c];
                e_target[cdb_tag[c*T +: T]] <= cdb_target[c*XLEN +: XLEN];
            end
        for (int i = 0; i < DISP_W; i++)
            if (accept && dp_valid[i]) begin
                e_dest[tail[T-1:0] + T'(i)] <= dp_dest[i*REG_W +: REG_W];
                e_pc[tail[T-1:0] + T'(i)]   <= dp_pc[i*XLEN +: XLEN];
                e_npc[tail[T-1:0] + T'(i)]  <= dp_npc[i*XLEN +: XLEN];
                e_br[tail[T-1:0] + T'(i)]   <= dp_is_branch[i];
            end
    end
endmodule

// File: tb/tb_rob_superscalar.sv
// tb_rob_superscalar: directed and random stimulus against a queue-based
// reference model of the reorder buffer.
module tb_rob_superscalar;
    localparam int DEPTH = 32, DW = 2, CW = 2, RW = 2;
    localparam int XLEN = 32, REG_W = 5, T = 5;

    logic                   clock = 1'b0;
    logic                   reset, squash;
    logic [DW-1:0]          dp_valid, dp_is_branch;
    logic [DW*REG_W-1:0]    dp_dest;
    logic [DW*XLEN-1:0]     dp_pc, dp_npc;
    logic                   dp_ready;
    logic [DW*T-1:0]        dp_tag;
    logic [CW-1:0]          cdb_valid, cdb_taken;
    logic [CW*T-1:0]        cdb_tag;
    logic [CW*XLEN-1:0]     cdb_value, cdb_target;
    logic [RW-1:0]          rt_valid;
    logic [RW*REG_W-1:0]    rt_dest;
    logic [RW*XLEN-1:0]     rt_value;
    logic [RW*T-1:0]        rt_tag;
    logic                   mispredict;
    logic [XLEN-1:0]        redirect_pc;
    logic [T:0]             free_count;

    rob_superscalar dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dp_valid(dp_valid), .dp_dest(dp_dest), .dp_pc(dp_pc),
        .dp_npc(dp_npc), .dp_is_branch(dp_is_branch),
        .dp_ready(dp_ready), .dp_tag(dp_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .rt_valid(rt_valid), .rt_dest(rt_dest), .rt_value(rt_value),
        .rt_tag(rt_tag), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .free_count(free_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        logic [4:0]  dest;
        logic [31:0] pc, npc, value, target;
        bit          br, done, taken;
    } ent_t;

    ent_t q[$];
    int   tail_tag, head_tag;
    int   exp_nr;
    bit   exp_mp, exp_ready;
    int   checks = 0, errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        squash = 0; dp_valid = '0; dp_is_branch = '0; dp_dest = '0;
        dp_pc = '0; dp_npc = '0; cdb_valid = '0; cdb_taken = '0;
        cdb_tag = '0; cdb_value = '0; cdb_target = '0;
    endtask

    task automatic set_lane(int i, bit br, logic [31:0] pc, logic [31:0] npc);
        dp_valid[i] = 1'b1;
        dp_is_branch[i] = br;
        dp_dest[i*REG_W +: REG_W] = 5'($urandom);
        dp_pc[i*XLEN +: XLEN] = pc;
        dp_npc[i*XLEN +: XLEN] = npc;
    endtask

    task automatic set_cdb(int p, int tag, bit tk, logic [31:0] tgt);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*T +: T] = 5'(tag);
        cdb_value[p*XLEN +: XLEN] = $urandom;
        cdb_taken[p] = tk;
        cdb_target[p*XLEN +: XLEN] = tgt;
    endtask

    // Expected outputs follow from the oldest entries of the model queue.
    task automatic check_outputs();
        bit stop = 0;
        logic [31:0] act;
        exp_nr = 0;
        exp_mp = 0;
        exp_ready = (DEPTH - q.size()) >= DW;
        chk("free_count", free_count, DEPTH - q.size());
        chk("dp_ready", dp_ready, exp_ready);
        for (int i = 0; i < DW; i++)
            chk("dp_tag", dp_tag[i*T +: T], (tail_tag + i) % DEPTH);
        for (int k = 0; k < RW; k++) begin
            if (!stop && k < q.size() && q[k].done) begin
                exp_nr++;
                chk("rt_tag", rt_tag[k*T +: T], q[k].tag);
                chk("rt_dest", rt_dest[k*REG_W +: REG_W], q[k].dest);
                chk("rt_value", rt_value[k*XLEN +: XLEN], q[k].value);
                if (q[k].br) begin
                    act = q[k].taken ? q[k].target : q[k].pc + 32'd4;
                    exp_mp = act != q[k].npc;
                    if (exp_mp) chk("redirect_pc", redirect_pc, act);
                    stop = 1;
                end
            end else begin
                stop = 1;
            end
        end
        chk("rt_valid", rt_valid, (1 << exp_nr) - 1);
        chk("mispredict", mispredict, exp_mp);
    endtask

    task automatic update_model();
        ent_t e;
        if (reset || squash) begin
            q.delete(); tail_tag = 0; head_tag = 0;
        end else if (exp_mp) begin
            q.delete();
            head_tag = (head_tag + exp_nr) % DEPTH;
            tail_tag = head_tag;
        end else begin
            for (int c = 0; c < CW; c++)
                if (cdb_valid[c])
                    foreach (q[j])
                        if (q[j].tag == int'(cdb_tag[c*T +: T])) begin
                            q[j].done = 1;
                            q[j].value = cdb_value[c*XLEN +: XLEN];
                            q[j].taken = cdb_taken[c];
                            q[j].target = cdb_target[c*XLEN +: XLEN];
                        end
            repeat (exp_nr) void'(q.pop_front());
            head_tag = (head_tag + exp_nr) % DEPTH;
            if (exp_ready)
                for (int i = 0; i < DW; i++)
                    if (dp_valid[i]) begin
                        e = '{tag: tail_tag,
                              dest: dp_dest[i*REG_W +: REG_W],
                              pc: dp_pc[i*XLEN +: XLEN],
                              npc: dp_npc[i*XLEN +: XLEN],
                              value: 0, target: 0,
                              br: dp_is_branch[i], done: 0, taken: 0};
                        q.push_back(e);
                        tail_tag = (tail_tag + 1) % DEPTH;
                    end
        end
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clock);
        update_model();
        @(negedge clock);
        drive_idle();
    endtask

    task automatic rand_lane(int i);
        logic [31:0] pc = $urandom & ~32'd3;
        bit br = $urandom_range(7) == 0;
        logic [31:0] npc = (br && $urandom_range(1) == 1) ? ($urandom & ~32'd3)
                                                          : pc + 32'd4;
        set_lane(i, br, pc, npc);
    endtask

    initial begin
        int prev, cur, bt, a, b;
        drive_idle();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        q.delete(); tail_tag = 0; head_tag = 0;
        chk("reset_free", free_count, 32);
        chk("reset_ready", dp_ready, 1);
        chk("reset_rt_valid", rt_valid, 0);

        // Fill the buffer two per cycle, then try once more while full.
        repeat (16) begin
            rand_lane(0); rand_lane(1);
            cycle();
        end
        chk("full_free", free_count, 0);
        chk("full_ready", dp_ready, 0);
        rand_lane(0); rand_lane(1);
        cycle();
        squash = 1;
        cycle();

        // Out-of-order completion, in-order paired retire.
        repeat (2) begin
            set_lane(0, 0, 32'h40, 32'h44); set_lane(1, 0, 32'h44, 32'h48);
            cycle();
        end
        set_cdb(0, 3, 0, 0); cycle();
        set_cdb(0, 1, 0, 0); cycle();
        chk("t2_no_retire", rt_valid, 0);
        set_cdb(1, 0, 0, 0); cycle();
        chk("t2_pair01", rt_valid, 2'b11);
        chk("t2_tags01", rt_tag, {5'd1, 5'd0});
        set_cdb(0, 2, 0, 0); cycle();
        chk("t2_tags23", rt_tag, {5'd3, 5'd2});
        cycle();

        // Single-op stream wrapping the pointers.
        prev = -1;
        for (int i = 0; i < 42; i++) begin
            cur = -1;
            if (i < 40) begin
                cur = tail_tag;
                rand_lane(0);
                dp_is_branch[0] = 0;
            end
            if (prev >= 0) set_cdb(0, prev, 0, 0);
            prev = cur;
            cycle();
        end
        chk("wrap_free", free_count, 32);

        // Mispredicted taken branch at tag 5.
        squash = 1; cycle();
        set_lane(0, 0, 32'h0f0, 32'h0f4); set_lane(1, 0, 32'h0f4, 32'h0f8); cycle();
        set_lane(0, 0, 32'h0f8, 32'h0fc); set_lane(1, 0, 32'h0fc, 32'h100); cycle();
        set_lane(0, 0, 32'h0fc, 32'h100); set_lane(1, 1, 32'h100, 32'h104); cycle();
        set_lane(0, 0, 32'h104, 32'h108); set_lane(1, 0, 32'h108, 32'h10c);
        set_cdb(0, 0, 0, 0); set_cdb(1, 1, 0, 0); cycle();
        set_cdb(0, 2, 0, 0); set_cdb(1, 3, 0, 0); cycle();
        set_cdb(0, 4, 0, 0); cycle();
        set_cdb(0, 5, 1, 32'h200); cycle();
        chk("t4_mispredict", mispredict, 1);
        chk("t4_redirect", redirect_pc, 32'h200);
        chk("t4_rt_tag", rt_tag[T-1:0], 5);
        set_cdb(0, 6, 0, 0);
        set_lane(0, 0, 32'h500, 32'h504); set_lane(1, 0, 32'h504, 32'h508);
        cycle();
        chk("t4_flush_free", free_count, 32);
        chk("t4_flush_rt", rt_valid, 0);
        set_cdb(0, 6, 0, 0); cycle();

        // Correctly predicted branch retires alone.
        bt = tail_tag;
        set_lane(0, 1, 32'h300, 32'h304); set_lane(1, 0, 32'h304, 32'h308); cycle();
        set_cdb(0, bt, 0, 32'h999); set_cdb(1, (bt + 1) % DEPTH, 0, 0); cycle();
        chk("t5_branch_alone", rt_valid, 2'b01);
        chk("t5_no_mp", mispredict, 0);
        cycle();
        chk("t5_next", rt_valid, 2'b01);
        chk("t5_next_tag", rt_tag[T-1:0], (bt + 1) % DEPTH);
        cycle();

        // Squash wins over dispatch and completion.
        rand_lane(0); rand_lane(1); cycle();
        squash = 1;
        rand_lane(0); rand_lane(1);
        set_cdb(0, (tail_tag + DEPTH - 2) % DEPTH, 0, 0);
        cycle();
        chk("t6_free", free_count, 32);
        chk("t6_ready", dp_ready, 1);
        chk("t6_rt", rt_valid, 0);

        // Random traffic.
        repeat (600) begin
            squash = $urandom_range(63) == 0;
            case ($urandom_range(2))
                1: rand_lane(0);
                2: begin rand_lane(0); rand_lane(1); end
                default: ;
            endcase
            if (q.size() > 0) begin
                a = $urandom_range(q.size() - 1);
                set_cdb(0, q[a].tag, $urandom_range(1),
                        $urandom_range(1) ? q[a].npc : ($urandom & ~32'd3));
                b = $urandom_range(q.size() - 1);
                if (b != a)
                    set_cdb(1, q[b].tag, $urandom_range(1), q[b].npc);
            end else if ($urandom_range(3) == 0) begin
                set_cdb(0, tail_tag, 0, 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
